// File: rtl/display_scan_ctrl_if.sv
// Bundle between display_scan_ctrl and its data source: capture strobe and
// digit data in, registered scan outputs back.
// Latency: none (wires only). Backpressure: none; load is a fire-and-forget strobe.
// Signals: load/hexs/points/les/blink (source -> controller),
//          hex/an/p/le/pending/frame (controller -> display and source).
interface display_scan_ctrl_if #(
  parameter int DIGITS = 8
);
  logic                load;
  logic [4*DIGITS-1:0] hexs;
  logic [DIGITS-1:0]   points;
  logic [DIGITS-1:0]   les;
  logic [DIGITS-1:0]   blink;
  logic [3:0]          hex;
  logic [DIGITS-1:0]   an;
  logic                p;
  logic                le;
  logic                pending;
  logic                frame;

  // Source side: drives the digit data and observes the scan outputs.
  modport master (
    output load, hexs, points, les, blink,
    input  hex, an, p, le, pending, frame
  );

  // Controller side.
  modport slave (
    input  load, hexs, points, les, blink,
    output hex, an, p, le, pending, frame
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// Multiplexed digit scan controller with frame-synchronous, tear-free data update.
// Latency: outputs registered; a load becomes visible at the next frame boundary.
// Backpressure: none; repeated loads before the boundary overwrite (last wins).
// Ports: clk, rst_n (sync, active low), bus (display_scan_ctrl_if.slave).
// Optional feature: define DISP_SCAN_BLINK_EN for per-digit blinking with a
// phase that toggles every BLINK_DIV frames.
module display_scan_ctrl #(
  parameter int DIGITS    = 8,
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 16,
  parameter int BLINK_DIV = 64
) (
  input logic                clk,
  input logic                rst_n,
  display_scan_ctrl_if.slave bus
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(DIGITS);
  localparam logic [DW-1:0] DIV_LAST  = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] BLANK_END = DW'(BLANK_CYC);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  // Scan position
  logic [DW-1:0] div_q, div_d;
  logic [IW-1:0] idx_q, idx_d;

  // Display (shown) and pending (staged) copies of the digit data
  logic [DIGITS-1:0][3:0] disp_hex_q, disp_hex_d;
  logic [DIGITS-1:0]      disp_pt_q, disp_pt_d;
  logic [DIGITS-1:0]      disp_le_q, disp_le_d;
  logic [DIGITS-1:0][3:0] pend_hex_q, pend_hex_d;
  logic [DIGITS-1:0]      pend_pt_q, pend_pt_d;
  logic [DIGITS-1:0]      pend_le_q, pend_le_d;
  logic                   pending_q, pending_d;

  // Registered outputs
  logic [3:0]        hex_q, hex_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic              p_q, p_d;
  logic              le_q, le_d;
  logic              frame_q, frame_d;

  logic slot_end;
  logic wrap;

`ifdef DISP_SCAN_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [DIGITS-1:0] disp_blk_q, disp_blk_d;
  logic [DIGITS-1:0] pend_blk_q, pend_blk_d;
  logic [BW-1:0]     blink_cnt_q, blink_cnt_d;
  logic              phase_q, phase_d;
`endif

  always_comb begin
    div_d      = div_q;
    idx_d      = idx_q;
    disp_hex_d = disp_hex_q;
    disp_pt_d  = disp_pt_q;
    disp_le_d  = disp_le_q;
    pend_hex_d = pend_hex_q;
    pend_pt_d  = pend_pt_q;
    pend_le_d  = pend_le_q;
    pending_d  = pending_q;
`ifdef DISP_SCAN_BLINK_EN
    disp_blk_d  = disp_blk_q;
    pend_blk_d  = pend_blk_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
`endif

    slot_end = (div_q == DIV_LAST);
    wrap     = slot_end && (idx_q == IDX_LAST);

    if (slot_end) begin
      div_d = '0;
      idx_d = wrap ? '0 : idx_q + IW'(1);
    end else begin
      div_d = div_q + DW'(1);
    end

    // Display registers only change on the wrap edge, so a frame is never torn.
    // A load landing exactly on the boundary bypasses the staging copy.
    if (wrap) begin
      if (bus.load) begin
        disp_hex_d = bus.hexs;
        disp_pt_d  = bus.points;
        disp_le_d  = bus.les;
`ifdef DISP_SCAN_BLINK_EN
        disp_blk_d = bus.blink;
`endif
        pending_d  = 1'b0;
      end else if (pending_q) begin
        disp_hex_d = pend_hex_q;
        disp_pt_d  = pend_pt_q;
        disp_le_d  = pend_le_q;
`ifdef DISP_SCAN_BLINK_EN
        disp_blk_d = pend_blk_q;
`endif
        pending_d  = 1'b0;
      end
    end else if (bus.load) begin
      pend_hex_d = bus.hexs;
      pend_pt_d  = bus.points;
      pend_le_d  = bus.les;
`ifdef DISP_SCAN_BLINK_EN
      pend_blk_d = bus.blink;
`endif
      pending_d  = 1'b1;
    end

`ifdef DISP_SCAN_BLINK_EN
    if (wrap) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end
`endif

    // Outputs are computed from next-state so the registered values line up
    // with the div/idx of the cycle they are presented in.
    hex_d   = disp_hex_d[idx_d];
    p_d     = disp_pt_d[idx_d];
    le_d    = disp_le_d[idx_d];
    frame_d = wrap;
    an_d    = '1;
    if (div_d >= BLANK_END) begin
      an_d[idx_d] = 1'b0;
    end
`ifdef DISP_SCAN_BLINK_EN
    if (phase_d && disp_blk_d[idx_d]) begin
      an_d = '1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q      <= '0;
      idx_q      <= '0;
      disp_hex_q <= '0;
      disp_pt_q  <= '0;
      disp_le_q  <= '0;
      pend_hex_q <= '0;
      pend_pt_q  <= '0;
      pend_le_q  <= '0;
      pending_q  <= 1'b0;
      hex_q      <= '0;
      an_q       <= '1;
      p_q        <= 1'b0;
      le_q       <= 1'b0;
      frame_q    <= 1'b0;
`ifdef DISP_SCAN_BLINK_EN
      disp_blk_q  <= '0;
      pend_blk_q  <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
`endif
    end else begin
      div_q      <= div_d;
      idx_q      <= idx_d;
      disp_hex_q <= disp_hex_d;
      disp_pt_q  <= disp_pt_d;
      disp_le_q  <= disp_le_d;
      pend_hex_q <= pend_hex_d;
      pend_pt_q  <= pend_pt_d;
      pend_le_q  <= pend_le_d;
      pending_q  <= pending_d;
      hex_q      <= hex_d;
      an_q       <= an_d;
      p_q        <= p_d;
      le_q       <= le_d;
      frame_q    <= frame_d;
`ifdef DISP_SCAN_BLINK_EN
      disp_blk_q  <= disp_blk_d;
      pend_blk_q  <= pend_blk_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
`endif
    end
  end

  assign bus.hex     = hex_q;
  assign bus.an      = an_q;
  assign bus.p       = p_q;
  assign bus.le      = le_q;
  assign bus.pending = pending_q;
  assign bus.frame   = frame_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl with DIGITS=4, SCAN_DIV=4, BLANK_CYC=1, BLINK_DIV=1.
// Loads push the data they should show onto a queue tagged with the frame it
// takes effect in; every cycle the expected scan outputs are derived from the
// cycle count since reset and the data popped for the current frame.
module tb_display_scan_ctrl;

  localparam int DIGITS = 4;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  display_scan_ctrl_if #(.DIGITS(DIGITS)) bus ();

  display_scan_ctrl #(
    .DIGITS   (DIGITS),
    .SCAN_DIV (4),
    .BLANK_CYC(1),
    .BLINK_DIV(1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    int         eff;
    logic [15:0] h;
    logic [3:0]  pt;
    logic [3:0]  le;
    logic [3:0]  bl;
  } ld_t;

  ld_t sb_q[$];

  int t;            // cycles since the last reset edge
  int pend_load_t;  // cycle of the last non-boundary load, -1 if none
  int n_assert;
  int n_fail;

  logic [15:0] m_hex;
  logic [3:0]  m_pt, m_le, m_bl;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, got, exp);
    end
  endtask

  task automatic check_cycle();
    int div;
    int idx;
    ld_t e;
    logic [3:0] ex_an;
    logic ex_pend;
    logic ex_frame;
    if (t % 16 == 0) begin
      while (sb_q.size() > 0 && sb_q[0].eff <= t / 16) begin
        e = sb_q.pop_front();
        m_hex = e.h;
        m_pt  = e.pt;
        m_le  = e.le;
        m_bl  = e.bl;
      end
    end
    div = t % 4;
    idx = (t / 4) % 4;
    ex_an = 4'b1111;
    if (div >= 1) ex_an[idx] = 1'b0;
`ifdef DISP_SCAN_BLINK_EN
    if (((t / 16) % 2 == 1) && m_bl[idx]) ex_an = 4'b1111;
`endif
    ex_pend  = (pend_load_t >= 0) && (pend_load_t / 16 == t / 16) && (pend_load_t < t);
    ex_frame = (t > 0) && (t % 16 == 0);
    chk("an",      16'(bus.an),      16'(ex_an));
    chk("hex",     16'(bus.hex),     16'(m_hex[idx*4 +: 4]));
    chk("p",       16'(bus.p),       16'(m_pt[idx]));
    chk("le",      16'(bus.le),      16'(m_le[idx]));
    chk("pending", 16'(bus.pending), 16'(ex_pend));
    chk("frame",   16'(bus.frame),   16'(ex_frame));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    bus.load = 1'b0;
    t++;
    check_cycle();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Advance to the given cycle-within-frame (at most one frame of ticks).
  task automatic run_to(input int ph);
    for (int i = 0; i < 16 && (t % 16 != ph); i++) tick();
  endtask

  task automatic do_load(input logic [15:0] h, input logic [3:0] pt,
                         input logic [3:0] le, input logic [3:0] bl);
    ld_t e;
    bus.load   = 1'b1;
    bus.hexs   = h;
    bus.points = pt;
    bus.les    = le;
    bus.blink  = bl;
    e.eff = t / 16 + 1;
    e.h   = h;
    e.pt  = pt;
    e.le  = le;
    e.bl  = bl;
    sb_q.push_back(e);
    if (t % 16 != 15) pend_load_t = t;
    tick();
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    bus.load = 1'b0;
    t = 0;
    sb_q.delete();
    pend_load_t = -1;
    m_hex = '0;
    m_pt  = '0;
    m_le  = '0;
    m_bl  = '0;
    check_cycle();
  endtask

  initial begin
    n_assert    = 0;
    n_fail      = 0;
    t           = 0;
    pend_load_t = -1;
    m_hex = '0;
    m_pt  = '0;
    m_le  = '0;
    m_bl  = '0;
    rst_n      = 1'b0;
    bus.load   = 1'b0;
    bus.hexs   = '0;
    bus.points = '0;
    bus.les    = '0;
    bus.blink  = '0;

    // Reset state and free-running scan pattern
    do_reset(3);
    run(20);

    // Mid-frame load: staged, then shown from the next frame
    run_to(5);
    do_load(16'h1234, 4'b0101, 4'b1100, 4'b0010);
    run_to(0);
    run(20);

    // Two loads in one frame: last wins
    run_to(6);
    do_load(16'hAAAA, 4'b1111, 4'b1111, 4'b0000);
    run(3);
    do_load(16'h5555, 4'b0000, 4'b1010, 4'b0001);
    run_to(0);
    run(20);

    // Load on the boundary cycle: applied directly, pending never set
    run_to(15);
    do_load(16'hBEEF, 4'b1001, 4'b0110, 4'b0100);
    run(34);

    // Boundary load while data is already staged: live inputs win
    run_to(3);
    do_load(16'h1111, 4'b1111, 4'b0000, 4'b1111);
    run_to(15);
    do_load(16'hC0DE, 4'b0011, 4'b1111, 4'b1000);
    run(20);

    // Reset mid-frame with data staged: everything discarded
    run_to(7);
    do_load(16'h9876, 4'b1111, 4'b1111, 4'b1111);
    run(2);
    do_reset(1);
    run(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 Parameter DIGITS, default 8: number of multiplexed digits, legal range 2..16.
REQ-002 Parameter SCAN_DIV, default 100000: clk cycles per digit slot, at least 4.
REQ-003 Parameter BLANK_CYC, default 16: dead-time cycles at the start of each slot, less than SCAN_DIV.
REQ-004 Parameter BLINK_DIV, default 64: completed frames per blink phase toggle, at least 1.
REQ-005 The block SHALL use one clock; reset is synchronous and active-low.
REQ-006 Port clk, input, 1: system clock, rising edge.
REQ-007 Port rst_n, input, 1: synchronous active-low reset.
REQ-008 Port load, input, 1: single-cycle strobe that captures hexs, points, les and blink.
REQ-009 Port hexs, input, 4*DIGITS: nibble i at [4i+3:4i] belongs to digit i.
REQ-010 Port points, input, DIGITS: decimal point per digit.
REQ-011 Port les, input, DIGITS: LED enable per digit.
REQ-012 Port blink, input, DIGITS: per-digit blink request.
REQ-013 Port hex, output, 4: nibble of the active digit.
REQ-014 Port an, output, DIGITS: active-low one-hot anode select.
REQ-015 Port p, output, 1: decimal point of the active digit.
REQ-016 Port le, output, 1: LED enable of the active digit.
REQ-017 Port pending, output, 1: high while captured data waits for the next frame boundary.
REQ-018 Port frame, output, 1: one-cycle pulse when the scan index wraps from DIGITS-1 to 0.

Function
REQ-019 All outputs SHALL be registered and SHALL change only on the rising edge of clk.
REQ-020 Counter div SHALL count 0..SCAN_DIV-1 and wrap to 0; the cycle in which div=SCAN_DIV-1 is the slot end.
REQ-021 At each slot end, scan index idx SHALL advance by 1, wrapping from DIGITS-1 to 0.
REQ-022 frame SHALL be high exactly in the cycle after the wrap of idx to 0.
REQ-023 While div<BLANK_CYC, an SHALL be all ones; otherwise an SHALL have bit idx at 0 and all other bits at 1.
REQ-024 hex, p and le SHALL reflect display-register entry idx throughout the slot, including the blank window.
REQ-025 On load, the inputs SHALL be captured into pending registers and pending SHALL be set to 1.
REQ-026 At a frame boundary (idx wrap) with pending=1, the pending registers SHALL be copied to the display registers and pending SHALL be cleared.
REQ-027 If load coincides with a frame boundary, the display registers SHALL take the live inputs directly and pending SHALL end at 0.
REQ-028 A second load before the boundary SHALL overwrite the pending registers; the last load wins.
REQ-029 Display registers SHALL never change mid-frame, so output is tear-free.

Reset
REQ-030 When rst_n=0 at a clk edge, the block SHALL load: div=0, idx=0, an all ones, hex=0, p=0, le=0, pending=0, frame=0, blink phase=0, and display and pending registers all 0.
REQ-031 Reset asserted mid-slot or mid-frame SHALL discard any pending data.
REQ-032 The first active anode after reset release SHALL be digit 0, once BLANK_CYC cycles have elapsed.

Configuration
REQ-033 Macro DISP_SCAN_BLINK_EN, when defined:
- A frame counter SHALL toggle the blink phase every BLINK_DIV frames.
- While phase=1 and display blink bit idx is 1, an SHALL be all ones for the whole slot.
REQ-034 When DISP_SCAN_BLINK_EN is undefined, the blink port SHALL be accepted but ignored, no blink counter SHALL exist, and there SHALL be no blanking beyond BLANK_CYC.

Verification
REQ-035 DIGITS=4, SCAN_DIV=4, BLANK_CYC=1, reset release -> an sequence 1111,1110,1110,1110,1111,1101,... and frame pulses every 16 cycles.
REQ-036 load with hexs=16'h1234 mid-frame -> pending=1; hex shows old data until the next frame, then 4,3,2,1 for idx 0..3; pending=0.
REQ-037 load hexs=16'hAAAA, then load hexs=16'h5555 in the same frame -> the next frame shows only 5.
REQ-038 load exactly at the frame-boundary cycle with hexs=16'hBEEF -> the next frame shows F,E,E,B and pending stays 0.
REQ-039 DISP_SCAN_BLINK_EN, BLINK_DIV=1, blink=4'b0010 -> an bit 1 stays high in every odd frame; other digits are unaffected.
REQ-040 rst_n low for 1 cycle mid-frame with pending=1 -> all outputs take reset values and pending=0; the scan restarts at idx 0.
